// File: rtl/cpu_icache_burst.sv
// Direct-mapped instruction cache that fills one line per miss as a burst of word fetches.
// Optional macro ICACHE_CRITICAL_WORD_FIRST_EN: start each fill at the missed word and wrap.
module cpu_icache_burst #(
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic [15:0] request_address,
  output logic [15:0] address,
  output logic [15:0] data,
  output logic        cache_miss,
  input  logic        invalidate,
  output logic        memory_ready,
  input  logic        memory_valid,
  output logic [15:0] memory_address,
  input  logic [15:0] memory_data,
  output logic [1:0]  dbg_state
);
  localparam int TAG_BITS = 16 - INDEX_BITS - WORD_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << (INDEX_BITS + WORD_BITS);
  localparam int LB       = 16 - WORD_BITS;
  localparam logic [WORD_BITS-1:0] WORD_ONE = WORD_BITS'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_address_x;
  logic [LINES-1:0]      r_valid;
  logic [15:0]           r_data_ram [WORDS];
  logic [TAG_BITS-1:0]   r_tag_ram  [LINES];
  logic [15:0]           r_data_q;
  logic [TAG_BITS-1:0]   r_tag_q;
  logic [LB-1:0]         r_line;
  logic [WORD_BITS-1:0]  r_count;
  logic [WORD_BITS-1:0]  r_last;

  logic [INDEX_BITS-1:0] w_index_x;
  logic [INDEX_BITS-1:0] w_index_rq;
  logic [INDEX_BITS-1:0] w_fill_index;
  logic [TAG_BITS-1:0]   w_tag_x;
  logic [TAG_BITS-1:0]   w_fill_tag;
  logic [WORD_BITS-1:0]  w_start;
  logic                  w_accept;
  logic                  w_commit;

  assign w_index_x    = r_address_x[WORD_BITS +: INDEX_BITS];
  assign w_tag_x      = r_address_x[15 -: TAG_BITS];
  assign w_index_rq   = request_address[WORD_BITS +: INDEX_BITS];
  assign w_fill_index = r_line[0 +: INDEX_BITS];
  assign w_fill_tag   = r_line[LB-1 -: TAG_BITS];

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign w_start = r_address_x[WORD_BITS-1:0];
`else
  assign w_start = '0;
`endif

  // Handshake: memory_ready is held for the whole FILL state; a word is accepted on
  // every rising edge where memory_ready and memory_valid are both high.
  assign w_accept = (r_state == FILL) && memory_valid;
  assign w_commit = w_accept && (r_count == r_last);

  assign cache_miss = (r_state != IDLE) || !r_valid[w_index_x] || (r_tag_q != w_tag_x);
  assign address    = r_address_x;
  assign data       = r_data_q;
  assign dbg_state  = r_state;

  always_comb begin
    w_state_nxt    = r_state;
    memory_ready   = 1'b0;
    memory_address = '0;
    case (r_state)
      IDLE: begin
        if (cache_miss) w_state_nxt = FILL;
      end
      FILL: begin
        memory_ready   = 1'b1;
        memory_address = {r_line, r_count};
        if (w_commit) w_state_nxt = SETTLE;
      end
      SETTLE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The line is latched at the miss so later request changes cannot redirect the fill.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_state     <= IDLE;
      r_address_x <= '0;
      r_line      <= '0;
      r_count     <= '0;
      r_last      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_address_x <= request_address;
      if ((r_state == IDLE) && cache_miss) begin
        r_line  <= r_address_x[15:WORD_BITS];
        r_count <= w_start;
        r_last  <= w_start - WORD_ONE;
      end else if (w_accept) begin
        r_count <= r_count + WORD_ONE;
      end
    end
  end

  // Invalidate takes priority over the commit of the final word.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_valid <= '0;
    end else if (invalidate) begin
      r_valid <= '0;
    end else if (w_commit) begin
      r_valid[w_fill_index] <= 1'b1;
    end
  end

  // Synchronous-read RAMs; a read concurrent with a write returns the old contents.
  always_ff @(posedge CLK) begin
    if (RSTb && w_accept) r_data_ram[{w_fill_index, r_count}] <= memory_data;
    if (RSTb && w_commit) r_tag_ram[w_fill_index] <= w_fill_tag;
    r_data_q <= r_data_ram[request_address[INDEX_BITS+WORD_BITS-1:0]];
    r_tag_q  <= r_tag_ram[w_index_rq];
  end

endmodule

// File: tb/tb_cpu_icache_burst.sv
// Self-checking bench for cpu_icache_burst: directed vector table, hand-written burst
// corner cases and randomized accesses against a line-level cache model.
module tb_cpu_icache_burst;
  localparam int IB = 6;
  localparam int WB = 2;
  localparam int NW = 1 << WB;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic [15:0] request_address = '0;
  logic [15:0] address;
  logic [15:0] data;
  logic        cache_miss;
  logic        invalidate = 1'b0;
  logic        memory_ready;
  logic        memory_valid = 1'b0;
  logic [15:0] memory_address;
  logic [15:0] memory_data = '0;
  logic [1:0]  dbg_state;

  cpu_icache_burst #(.INDEX_BITS(IB), .WORD_BITS(WB)) dut (
    .CLK            (CLK),
    .RSTb           (RSTb),
    .request_address(request_address),
    .address        (address),
    .data           (data),
    .cache_miss     (cache_miss),
    .invalidate     (invalidate),
    .memory_ready   (memory_ready),
    .memory_valid   (memory_valid),
    .memory_address (memory_address),
    .memory_data    (memory_data),
    .dbg_state      (dbg_state)
  );

  always #5 CLK = ~CLK;

  // Reference model: resident tag/valid per line and the words captured at fill time.
  bit          m_valid [1 << IB];
  logic [7:0]  m_tag   [1 << IB];
  logic [15:0] m_data  [1 << (IB + WB)];
  logic [15:0] acc_q[$];
  int          resp_mode;
  int          mem_mode;
  int          n_checks;
  int          n_pass;

  typedef struct {
    logic [15:0] addr;
    bit          exp_miss;
    logic [15:0] exp_data;
  } vec_t;
  vec_t vecs [5];

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    if (mem_mode == 0) return 16'hA000 + 16'(a[WB-1:0]);
    return (a * 16'h9E37) ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] exp_fill_addr(input logic [15:0] a, input int i);
    logic [WB-1:0] s;
    s = CWF ? a[WB-1:0] : '0;
    s = s + WB'(i);
    return {a[15:WB], s};
  endfunction

  function automatic bit model_hit(input logic [15:0] a);
    logic [IB-1:0] idx;
    idx = a[WB+IB-1:WB];
    return m_valid[idx] && (m_tag[idx] == a[15:WB+IB]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < (1 << IB); i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [15:0] a);
    logic [IB-1:0] idx;
    idx = a[WB+IB-1:WB];
    m_valid[idx] = 1'b1;
    m_tag[idx]   = a[15:WB+IB];
    for (int w = 0; w < NW; w++) m_data[{idx, WB'(w)}] = mem_fn({a[15:WB], WB'(w)});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Memory responder: resp_mode 0 = bench drives by hand, 1 = always valid, 2 = random stalls.
  initial begin
    forever begin
      @(negedge CLK);
      if (resp_mode != 0) begin
        if (memory_ready && (resp_mode == 1 || $urandom_range(0, 3) != 0)) begin
          memory_valid = 1'b1;
          memory_data  = mem_fn(memory_address);
          acc_q.push_back(memory_address);
        end else begin
          memory_valid = 1'b0;
          memory_data  = 16'($urandom);
        end
      end
    end
  end

  task automatic do_access(input logic [15:0] a, input bit inv, input bit exp_miss,
                           input logic [15:0] exp_data);
    int n;
    acc_q.delete();
    request_address = a;
    invalidate      = inv;
    @(negedge CLK);
    invalidate = 1'b0;
    check("address", 32'(address), 32'(a));
    check("miss_flag", 32'(cache_miss), 32'(exp_miss));
    if (!exp_miss) check("no_fetch_on_hit", 32'(memory_ready), 32'd0);
    if (exp_miss) begin
      n = 0;
      while (cache_miss && n < 200) begin
        @(negedge CLK);
        n++;
      end
      check("fill_done", 32'(n < 200), 32'd1);
      check("fill_len", 32'(acc_q.size()), 32'(NW));
      for (int i = 0; i < NW && i < acc_q.size(); i++)
        check("fill_addr", 32'(acc_q[i]), 32'(exp_fill_addr(a, i)));
      model_fill(a);
    end
    check("data", 32'(data), 32'(exp_data));
  endtask

  task automatic feed_word(input logic [15:0] ea);
    check("burst_ready", 32'(memory_ready), 32'd1);
    check("burst_addr", 32'(memory_address), 32'(ea));
    memory_valid = 1'b1;
    memory_data  = mem_fn(ea);
    @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [15:0] ed;
    bit          inv;
    bit          hit;
    vecs[0] = '{16'h0102, 1'b1, 16'hA002};
    vecs[1] = '{16'h0101, 1'b0, 16'hA001};
    vecs[2] = '{16'h0200, 1'b1, 16'hA000};
    vecs[3] = '{16'h0100, 1'b1, 16'hA000};
    vecs[4] = '{16'h0103, 1'b0, 16'hA003};
    resp_mode = 0;
    mem_mode  = 0;
    n_checks  = 0;
    n_pass    = 0;
    model_clear();

    repeat (3) @(negedge CLK);
    check("rst_miss", 32'(cache_miss), 32'd1);
    check("rst_ready", 32'(memory_ready), 32'd0);
    check("rst_mem_addr", 32'(memory_address), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Address 0 misses straight out of reset, so line 0 is filled first.
    RSTb      = 1'b1;
    resp_mode = 1;
    do_access(16'h0000, 1'b0, 1'b1, 16'hA000);
    for (int i = 0; i < 5; i++) do_access(vecs[i].addr, 1'b0, vecs[i].exp_miss, vecs[i].exp_data);

    // Stray memory_valid while idle must not touch the RAM.
    resp_mode = 0;
    @(negedge CLK);
    memory_valid = 1'b1;
    memory_data  = 16'hDEAD;
    @(negedge CLK);
    memory_valid = 1'b0;
    do_access(16'h0101, 1'b0, 1'b0, 16'hA001);
    do_access(16'h0100, 1'b0, 1'b0, 16'hA000);

    // Mid-burst stall with request_address wandering.
    request_address = 16'h0202;
    @(negedge CLK);
    check("miss_0202", 32'(cache_miss), 32'd1);
    @(negedge CLK);
    feed_word(exp_fill_addr(16'h0202, 0));
    feed_word(exp_fill_addr(16'h0202, 1));
    memory_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) request_address = 16'h3F05;
      if (k == 6) request_address = 16'h0202;
      @(negedge CLK);
      check("stall_ready", 32'(memory_ready), 32'd1);
      check("stall_addr", 32'(memory_address), 32'(exp_fill_addr(16'h0202, 2)));
    end
    feed_word(exp_fill_addr(16'h0202, 2));
    feed_word(exp_fill_addr(16'h0202, 3));
    memory_valid = 1'b0;
    check("settle_ready", 32'(memory_ready), 32'd0);
    check("settle_state", 32'(dbg_state), 32'd2);
    check("settle_miss", 32'(cache_miss), 32'd1);
    @(negedge CLK);
    model_fill(16'h0202);
    check("hit_after_fill", 32'(cache_miss), 32'd0);
    check("data_0202", 32'(data), 32'hA002);

    // Invalidate coincident with the final word leaves the line invalid.
    request_address = 16'h0100;
    @(negedge CLK);
    check("miss_0100", 32'(cache_miss), 32'd1);
    @(negedge CLK);
    for (int i = 0; i < NW; i++) begin
      if (i == NW - 1) invalidate = 1'b1;
      feed_word(exp_fill_addr(16'h0100, i));
    end
    invalidate   = 1'b0;
    memory_valid = 1'b0;
    model_clear();
    check("inv_commit_ready", 32'(memory_ready), 32'd0);
    @(negedge CLK);
    check("inv_commit_miss", 32'(cache_miss), 32'd1);
    resp_mode = 1;
    do_access(16'h0100, 1'b0, 1'b1, 16'hA000);

    // Reset after the second word abandons the burst.
    resp_mode       = 0;
    request_address = 16'h0100;
    invalidate      = 1'b1;
    @(negedge CLK);
    invalidate = 1'b0;
    model_clear();
    check("inv_miss", 32'(cache_miss), 32'd1);
    @(negedge CLK);
    feed_word(exp_fill_addr(16'h0100, 0));
    feed_word(exp_fill_addr(16'h0100, 1));
    memory_valid = 1'b0;
    RSTb = 1'b0;
    @(negedge CLK);
    check("midrst_ready", 32'(memory_ready), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_mem_addr", 32'(memory_address), 32'd0);
    check("midrst_miss", 32'(cache_miss), 32'd1);
    RSTb = 1'b1;
    model_clear();
    resp_mode = 1;
    do_access(16'h0000, 1'b0, 1'b1, 16'hA000);
    do_access(16'h0100, 1'b0, 1'b1, 16'hA000);

    // Randomized accesses over a few colliding tags and indices.
    mem_mode  = 1;
    resp_mode = 2;
    for (int k = 0; k < 120; k++) begin
      a   = {8'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      inv = ($urandom_range(0, 7) == 0);
      if (inv) model_clear();
      hit = model_hit(a);
      ed  = hit ? m_data[a[IB+WB-1:0]] : mem_fn(a);
      do_access(a, inv, !hit, ed);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_icache_burst.md
CPU_ICACHE_BURST -- requirements
Module: cpu_icache_burst

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 6, meaning log2 of the number of cache lines.
REQ-002 The block SHALL have parameter WORD_BITS, default 2, meaning log2 of the 16-bit words per line; TAG_BITS = 16 - INDEX_BITS - WORD_BITS SHALL be derived.
REQ-003 The block SHALL have port CLK, input, 1, meaning clock; all logic is rising-edge.
REQ-004 The block SHALL have port RSTb, input, 1, meaning reset, synchronous, active-low.
REQ-005 The block SHALL have port request_address, input, 16, meaning word address requested by the CPU.
REQ-006 The block SHALL have port address, output, 16, meaning the word address that data belongs to.
REQ-007 The block SHALL have port data, output, 16, meaning the cached instruction word.
REQ-008 The block SHALL have port cache_miss, output, 1, meaning data is not valid for the last registered request.
REQ-009 The block SHALL have port invalidate, input, 1, meaning a one-cycle pulse that clears all lines.
REQ-010 The block SHALL have port memory_ready, output, 1, meaning a word fetch is requested from the arbiter.
REQ-011 The block SHALL have port memory_valid, input, 1, meaning memory_data holds the word at memory_address this cycle.
REQ-012 The block SHALL have port memory_address, output, 16, meaning the fill word address.
REQ-013 The block SHALL have port memory_data, input, 16, meaning fill data.

Function
REQ-014 The block SHALL register request_address into address_x each cycle and drive address = address_x.
REQ-015 The data RAM (2^(INDEX_BITS+WORD_BITS) x 16) and tag RAM (2^INDEX_BITS x TAG_BITS) SHALL be synchronous-read; data SHALL be valid one cycle after request_address on a hit.
REQ-016 Valid bits SHALL be a flop array of 2^INDEX_BITS bits.
REQ-017 The block SHALL drive cache_miss = 1 when state != IDLE, or valid[index(address_x)] = 0, or tag RAM output != tag(address_x).
REQ-018 The FSM SHALL have states IDLE, FILL and SETTLE.
REQ-019 In IDLE, on cache_miss = 1 the FSM SHALL latch line base = address_x with the word field zeroed, load word counter, and go to FILL.
REQ-020 In FILL the block SHALL hold memory_ready = 1 and memory_address = {tag, index, word counter}.
REQ-021 In FILL, each cycle with memory_valid = 1 SHALL write memory_data to the data RAM at {index, counter} and increment the counter modulo 2^WORD_BITS.
REQ-022 On the 2^WORD_BITS-th accepted word the block SHALL write the tag RAM, set the valid bit, deassert memory_ready the next cycle, and go to SETTLE.
REQ-023 SETTLE SHALL last exactly one cycle, forcing cache_miss = 1 so the RAM read reflects the committed line, then go to IDLE.
REQ-024 A memory_valid pulse outside FILL SHALL be ignored.
REQ-025 request_address changes during FILL SHALL NOT alter the line being filled.
REQ-026 invalidate = 1 SHALL clear all valid bits on the next edge; if coincident with the final-word commit, invalidate SHALL win and the line SHALL remain invalid.
REQ-027 Invalidate during FILL SHALL NOT abort the burst; the fill SHALL complete and set valid only if no invalidate occurs on the commit cycle.

Reset
REQ-028 With RSTb = 0 at an edge, state SHALL be IDLE, all valid bits 0, the counter 0, memory_ready 0, memory_address 0 and address_x 0; cache_miss SHALL read 1 after reset.
REQ-029 Reset during FILL SHALL abandon the burst at once, with no valid bit set for that line.

Configuration
REQ-030 With macro ICACHE_CRITICAL_WORD_FIRST_EN defined, a fill SHALL start at word(address_x) and wrap modulo the line, ending at word(address_x) - 1.
REQ-031 With ICACHE_CRITICAL_WORD_FIRST_EN undefined, every fill SHALL start at word 0 and end at word 2^WORD_BITS - 1.

Verification
REQ-032 Scenario: after reset, request 0x0102, memory returns 0xA000+offset -> memory_address sequence 0x0100..0x0103 (0x0102,0x0103,0x0100,0x0101 with macro), then request 0x0102 two cycles after SETTLE gives cache_miss = 0 and data 0xA002.
REQ-033 Scenario: after filling 0x0100 line, request 0x0101 -> hit next cycle with data 0xA001 and no memory_ready.
REQ-034 Scenario: filled 0x0100, request 0x0200 (same index, tag 0x02 vs 0x01) -> miss, refill, then 0x0100 misses again.
REQ-035 Scenario: memory_valid held low 10 cycles mid-burst -> memory_ready stays 1 and memory_address stays constant, with no RAM writes.
REQ-036 Scenario: invalidate on the final-word cycle -> line stays invalid, and a re-request of 0x0100 misses.
REQ-037 Scenario: RSTb low for 1 cycle after the 2nd fill word -> memory_ready = 0 next cycle, and a request of 0x0100 starts a fresh fill at the start word.
